// File: rtl/db_bus_pkg.sv
// db_bus_pkg: shared access-type codes and arbiter FSM states for the db_* bus
package db_bus_pkg;
  localparam logic [1:0] ACC_NONE  = 2'b00;
  localparam logic [1:0] ACC_READ  = 2'b01;
  localparam logic [1:0] ACC_WRITE = 2'b10;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/db_arbiter_if.sv
// db_arbiter_if: one db_* bus link; a requester uses master, a responder uses slave
interface db_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [1:0]        accessType;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataOut;
  logic [DATA_W-1:0] dataIn;
  logic              ready;
  logic              err;
  modport master(output accessType, addr, dataOut, input dataIn, ready, err);
  modport slave(input accessType, addr, dataOut, output dataIn, ready, err);
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin picker; a tie goes to the requester not granted last
module rr_arbiter2 (
  input  logic       clk,
  input  logic       res_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last_q, last_d;
  // one-hot pick while enabled; remember the winner of each real grant
  always_comb begin
    gnt    = !en ? 2'b00 : (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
    last_d = (gnt != 2'b00) ? gnt[1] : last_q;
  end
  // last winner register; reset to master 1 so master 0 takes the first tie
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/db_arbiter.sv
// db_arbiter: shares one db_* slave between two masters with round-robin grant and timeout abort
module db_arbiter
  import db_bus_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input logic          clk,
  input logic          res_n,
  db_arbiter_if.slave  m0,
  db_arbiter_if.slave  m1,
  db_arbiter_if.master db
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              err_q, err_d;
  logic [1:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] din0_q, din0_d;
  logic [DATA_W-1:0] din1_q, din1_d;
  logic [1:0]        req, gnt;
  logic              done, abort;
  assign req   = {m1.accessType != ACC_NONE, m0.accessType != ACC_NONE};
  assign done  = (state_q == BUSY) && db.ready;
  assign abort = (state_q == BUSY) && !db.ready && (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  rr_arbiter2 u_rr (
    .clk  (clk),
    .res_n(res_n),
    .req  (req),
    .en   (state_q == IDLE),
    .gnt  (gnt)
  );
  // next state, request latch on grant, timeout count and response capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    err_d   = err_q;
    type_d  = type_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    din0_d  = din0_q;
    din1_d  = din1_q;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          state_d = BUSY;
          sel_d   = gnt[1];
          cnt_d   = '0;
          type_d  = gnt[1] ? m1.accessType : m0.accessType;
          addr_d  = gnt[1] ? m1.addr : m0.addr;
          dout_d  = gnt[1] ? m1.dataOut : m0.dataOut;
        end
      end
      BUSY: begin
        if (done || abort) begin
          state_d = RESP;
          err_d   = abort;
          type_d  = ACC_NONE;
          din0_d  = sel_q ? din0_q : (done ? db.dataIn : '0);
          din1_d  = sel_q ? (done ? db.dataIn : '0) : din1_q;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      type_q  <= ACC_NONE;
      addr_q  <= '0;
      dout_q  <= '0;
      din0_q  <= '0;
      din1_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      din0_q  <= din0_d;
      din1_q  <= din1_d;
    end
  end
  assign db.accessType = type_q;
  assign db.addr       = addr_q;
  assign db.dataOut    = dout_q;
  assign m0.dataIn     = din0_q;
  assign m1.dataIn     = din1_q;
  assign m0.ready      = (state_q == RESP) && !sel_q;
  assign m1.ready      = (state_q == RESP) && sel_q;
  assign m0.err        = (state_q == RESP) && !sel_q && err_q;
  assign m1.err        = (state_q == RESP) && sel_q && err_q;
endmodule

// File: tb/tb_db_arbiter.sv
// tb_db_arbiter: directed and randomized checks of db_arbiter against a transaction-level model
module tb_db_arbiter;
  import db_bus_pkg::*;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic res_n = 1'b1;
  always #5 clk = ~clk;
  db_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) i0 ();
  db_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) i1 ();
  db_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) idb ();
  db_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .res_n(res_n),
    .m0   (i0),
    .m1   (i1),
    .db   (idb)
  );
  int checks = 0;
  int errors = 0;
  logic [1:0]    m_type[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_dout[2];
  int            m_mode[2];
  bit            done_p[2];
  logic          s_rdy;
  logic [DW-1:0] s_din;
  int            s_mode, s_cnt, s_lat;
  bit            stall;
  assign i0.accessType = m_type[0];
  assign i0.addr       = m_addr[0];
  assign i0.dataOut    = m_dout[0];
  assign i1.accessType = m_type[1];
  assign i1.addr       = m_addr[1];
  assign i1.dataOut    = m_dout[1];
  assign idb.ready     = s_rdy;
  assign idb.dataIn    = s_din;
  assign idb.err       = 1'b0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask
  // transaction-level model: who owns the bus, how long it has waited, what each side must see
  logic [1:0]    e_type;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_dout;
  logic [DW-1:0] e_din[2];
  logic          e_rdy[2], e_err[2];
  int            owner, waited, w;
  logic          lastg;
  bit            was_resp, r0, r1;
  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      e_type = ACC_NONE; e_addr = '0; e_dout = '0;
      e_din = '{'0, '0}; e_rdy = '{1'b0, 1'b0}; e_err = '{1'b0, 1'b0};
      owner = -1; waited = 0; lastg = 1'b1;
    end else begin
      was_resp = e_rdy[0] || e_rdy[1];
      e_rdy = '{1'b0, 1'b0};
      e_err = '{1'b0, 1'b0};
      if (was_resp) begin
        owner = -1;
      end else if (owner < 0) begin
        r0 = m_type[0] != ACC_NONE;
        r1 = m_type[1] != ACC_NONE;
        if (r0 || r1) begin
          w = (r0 && r1) ? ((lastg == 1'b1) ? 0 : 1) : (r1 ? 1 : 0);
          lastg = w[0]; owner = w; waited = 0;
          e_type = m_type[w]; e_addr = m_addr[w]; e_dout = m_dout[w];
        end
      end else if (s_rdy) begin
        e_din[owner] = s_din; e_rdy[owner] = 1'b1; e_type = ACC_NONE;
      end else if (waited == TO - 1) begin
        e_din[owner] = '0; e_rdy[owner] = 1'b1; e_err[owner] = 1'b1; e_type = ACC_NONE;
      end else begin
        waited++;
      end
    end
  end
  // every cycle out of reset, all DUT outputs must equal the model
  always @(negedge clk) begin
    if (res_n) begin
      chk("cmp_db_type", idb.accessType, e_type);
      chk("cmp_db_addr", idb.addr, e_addr);
      chk("cmp_db_dout", idb.dataOut, e_dout);
      chk("cmp_m0_din", i0.dataIn, e_din[0]);
      chk("cmp_m1_din", i1.dataIn, e_din[1]);
      chk("cmp_m0_rdy", i0.ready, e_rdy[0]);
      chk("cmp_m1_rdy", i1.ready, e_rdy[1]);
      chk("cmp_m0_err", i0.err, e_err[0]);
      chk("cmp_m1_err", i1.err, e_err[1]);
    end
  end
  // completion log for grant-order checks
  int            comp_q[$];
  logic [DW-1:0] comp_dout[$];
  always @(negedge clk) begin
    if (res_n && i0.ready) begin comp_q.push_back(0); comp_dout.push_back(idb.dataOut); end
    if (res_n && i1.ready) begin comp_q.push_back(1); comp_dout.push_back(idb.dataOut); end
  end
  task automatic new_req(input int x);
    m_type[x] = 2'($urandom_range(1, 3));
    m_addr[x] = $urandom;
    m_dout[x] = $urandom;
  endtask
  // background agents: mode 1 master drops after its ready, mode 2 master is random;
  // slave mode 1 answers after s_lat visible cycles, mode 2 answers randomly with stall bursts
  always @(posedge clk) begin
    #1;
    if (!res_n) begin
      done_p = '{1'b0, 1'b0};
    end else begin
      for (int x = 0; x < 2; x++) begin
        if (done_p[x]) begin
          done_p[x] = 1'b0;
          if (m_mode[x] == 1) m_type[x] = ACC_NONE;
          else if (m_mode[x] == 2) begin
            if ($urandom_range(0, 1) == 1) new_req(x);
            else m_type[x] = ACC_NONE;
          end
        end else if (m_mode[x] == 2 && m_type[x] == ACC_NONE && $urandom_range(0, 3) == 0) begin
          new_req(x);
        end
        if (e_rdy[x]) done_p[x] = 1'b1;
      end
      if (s_mode == 1) begin
        s_cnt = (e_type != ACC_NONE) ? s_cnt + 1 : 0;
        s_rdy = (s_cnt == s_lat);
        s_din = $urandom;
      end else if (s_mode == 2) begin
        if ($urandom_range(0, 39) == 0) stall = !stall;
        s_rdy = !stall && ($urandom_range(0, 2) == 0);
        s_din = $urandom;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  initial begin
    m_type = '{ACC_NONE, ACC_NONE}; m_addr = '{'0, '0}; m_dout = '{'0, '0};
    m_mode = '{0, 0}; s_mode = 0; s_cnt = 0; s_lat = 1; s_rdy = 1'b0; s_din = '0; stall = 1'b0;
    #1 res_n = 1'b0;
    #10;
    chk("rst_db_type", idb.accessType, 2'b00);
    chk("rst_db_addr", idb.addr, 0);
    chk("rst_m0_rdy", i0.ready, 0);
    chk("rst_m1_rdy", i1.ready, 0);
    chk("rst_m0_din", i0.dataIn, 0);
    step();
    #1 res_n = 1'b1;
    step();
    // single read from master 0, slave answers two cycles after the request
    m_type[0] = ACC_READ; m_addr[0] = 32'h100;
    chk("rd_idle_type", idb.accessType, 2'b00);
    step();
    chk("rd_db_type", idb.accessType, 2'b01);
    chk("rd_db_addr", idb.addr, 32'h100);
    step();
    chk("rd_m0_rdy_early", i0.ready, 0);
    s_rdy = 1'b1; s_din = 32'hDEADBEEF;
    step();
    s_rdy = 1'b0;
    chk("rd_m0_rdy", i0.ready, 1);
    chk("rd_m0_din", i0.dataIn, 32'hDEADBEEF);
    chk("rd_m0_err", i0.err, 0);
    chk("rd_m1_rdy", i1.ready, 0);
    chk("rd_db_idle", idb.accessType, 2'b00);
    step();
    m_type[0] = ACC_NONE;
    chk("rd_m0_rdy_once", i0.ready, 0);
    step();
    chk("stale_no_regrant", idb.accessType, 2'b00);
    step();
    chk("stale_still_idle", idb.accessType, 2'b00);
    // simultaneous requests right after reset: master 0 first, then master 1
    #1 res_n = 1'b0;
    step();
    #1 res_n = 1'b1;
    step();
    comp_q.delete(); comp_dout.delete();
    m_mode = '{1, 1}; s_mode = 1; s_lat = 2;
    m_type[0] = ACC_READ;  m_addr[0] = 32'h10; m_dout[0] = 32'h1111;
    m_type[1] = ACC_WRITE; m_addr[1] = 32'h20; m_dout[1] = 32'h55AA;
    repeat (20) step();
    chk("sim_count", comp_q.size(), 2);
    if (comp_q.size() == 2) begin
      chk("sim_first", comp_q[0], 0);
      chk("sim_second", comp_q[1], 1);
      chk("sim_m1_dout", comp_dout[1], 32'h55AA);
    end
    // continuous requests from both: completions strictly alternate
    m_mode = '{0, 0}; s_lat = 1;
    comp_q.delete();
    m_type[0] = ACC_READ;  m_addr[0] = 32'h40;
    m_type[1] = ACC_WRITE; m_addr[1] = 32'h50; m_dout[1] = 32'h77;
    for (int k = 0; k < 200 && comp_q.size() < 6; k++) step();
    m_type = '{ACC_NONE, ACC_NONE};
    chk("fair_count", comp_q.size(), 6);
    if (comp_q.size() == 6)
      for (int k = 0; k < 6; k++) chk("fair_order", comp_q[k], k % 2);
    repeat (4) step();
    // timeout: slave never answers master 1's read
    s_mode = 0; s_rdy = 1'b0; m_mode[1] = 1;
    step();
    m_type[1] = ACC_READ; m_addr[1] = 32'h300;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("to_busy_type", idb.accessType, 2'b01);
      chk("to_busy_rdy", i1.ready, 0);
    end
    step();
    chk("to_m1_rdy", i1.ready, 1);
    chk("to_m1_err", i1.err, 1);
    chk("to_m1_din", i1.dataIn, 0);
    chk("to_db_idle", idb.accessType, 2'b00);
    repeat (3) step();
    s_rdy = 1'b1; s_din = 32'h12345678;
    step();
    s_rdy = 1'b0;
    chk("late_m1_rdy", i1.ready, 0);
    chk("late_m0_rdy", i0.ready, 0);
    chk("late_db_idle", idb.accessType, 2'b00);
    step();
    chk("late_m1_din", i1.dataIn, 0);
    // reset while a write is outstanding
    m_mode = '{0, 0};
    m_type[0] = ACC_WRITE; m_addr[0] = 32'h500; m_dout[0] = 32'hCAFE;
    step();
    step();
    chk("mid_busy_type", idb.accessType, 2'b10);
    m_type[1] = ACC_READ; m_addr[1] = 32'h600;
    #1 res_n = 1'b0;
    #1;
    chk("mid_rst_type", idb.accessType, 2'b00);
    chk("mid_rst_addr", idb.addr, 0);
    chk("mid_rst_m0_rdy", i0.ready, 0);
    chk("mid_rst_m1_rdy", i1.ready, 0);
    step();
    #1 res_n = 1'b1;
    step();
    chk("post_rst_addr", idb.addr, 32'h500);
    chk("post_rst_type", idb.accessType, 2'b10);
    m_mode = '{1, 1}; s_mode = 1; s_lat = 1;
    repeat (20) step();
    // randomized traffic against the model
    m_mode = '{2, 2}; s_mode = 2;
    repeat (3000) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/db_arbiter.md
Name: db_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU data bus (db_* protocol).
- Shares a single memory/peripheral slave between master 0 (CPUCore data port) and master 1 (secondary requester, e.g. a UART/DMA engine).
- Uses round-robin grant, registered slave-side outputs, and a per-transaction timeout that returns an error to the master instead of hanging.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address width.
- TIMEOUT, 1024, cycles to wait for db_ready before aborting; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- res_n  input  1  reset, asynchronous and active-low.
- m0_accessType  input  2  master 0 request: 00 none, 01 read, 10 write, 11 forwarded opaquely.
- m0_addr  input  ADDR_W  master 0 address.
- m0_dataOut  input  DATA_W  master 0 write data.
- m0_dataIn  output  DATA_W  master 0 read data; valid when m0_ready=1.
- m0_ready  output  1  one-cycle completion pulse to master 0.
- m0_err  output  1  qualifies m0_ready; 1 means timeout abort.
- m1_accessType, m1_addr, m1_dataOut, m1_dataIn, m1_ready, m1_err: identical to the m0_* ports, for master 1.
- db_accessType  output  2  slave request type; 00 when idle.
- db_addr  output  ADDR_W  slave address.
- db_dataOut  output  DATA_W  slave write data.
- db_dataIn  input  DATA_W  slave read data.
- db_ready  input  1  slave completion, sampled only in BUSY.

Behaviour:
- Reset values (asynchronous, while res_n=0):
  - All outputs 0; db_accessType=00; state=IDLE.
  - last_grant=1, so master 0 wins the first tie.
  - Timeout counter=0.
- Request definition: mX_accessType != 00. A master holds type, addr and dataOut stable until it sees its mX_ready.
- IDLE:
  - If no requests, stay in IDLE.
  - If exactly one master requests, grant it.
  - If both request, grant the master != last_grant.
  - On grant, latch that master's type, addr and dataOut into the db_* output registers; set last_grant; clear the counter; go to BUSY.
  - Slave sees the request one cycle after the master raised it.
- BUSY:
  - db_* outputs are held constant.
  - db_ready=1: capture db_dataIn into the granted master's mX_dataIn register; drive db_accessType=00 next cycle; go to RESP with err=0.
  - db_ready=0 and TIMEOUT!=0 and counter==TIMEOUT-1: go to RESP with err=1, mX_dataIn=0, db_accessType=00.
  - Otherwise increment the counter.
  - Counter width is clog2(TIMEOUT+1) and it never wraps.
- RESP:
  - Assert the granted master's mX_ready (and mX_err if aborted) for exactly one cycle, then go to IDLE.
  - Requests are ignored in RESP, so a stale request is never re-granted.
- The non-granted master's ready/err stay 0. mX_dataIn holds its last value until the next completion for that master.
- Latency: request at cycle N → db request visible N+1 → db_ready at cycle M → mX_ready at M+1.
  - Minimum round trip is 3 cycles; back-to-back issue rate is one transaction per 3 cycles plus slave latency.
- db_ready outside BUSY is ignored, including a late ready after a timeout abort.
- Fairness: under continuous requests from both masters, grants strictly alternate.
- Reset mid-transaction: outputs drop immediately, no ready is returned, and the FSM restarts in IDLE.

Decomposition:
- Shared package db_bus_pkg holds:
  - access-type constants ACC_NONE=00, ACC_READ=01, ACC_WRITE=10;
  - state encoding IDLE/BUSY/RESP.
- Natural sub-module: rr_arbiter2, a small registered round-robin picker holding last_grant. It takes req[1:0] and a grant-enable input, and produces a one-hot gnt.
- Datapath muxes, the timeout counter and the FSM stay in db_arbiter.

Test Plan:
- Single read: m0 read at addr 0x100; slave returns 0xDEADBEEF with db_ready 2 cycles after request → db_accessType=01, db_addr=0x100 one cycle after request; m0_ready pulse with m0_dataIn=0xDEADBEEF, m0_err=0; m1_ready stays 0.
- Simultaneous requests after reset: m0 read at 0x10, m1 write 0x55AA to 0x20, both held, slave ready after 1 cycle → m0 served first, then m1 (db_dataOut=0x55AA, type 10); each gets exactly one ready pulse.
- Fairness: both masters request continuously for 6 transactions → grant sequence 0,1,0,1,0,1.
- Timeout: TIMEOUT=8, m1 read, slave never asserts ready → after 8 BUSY cycles, m1_ready=1, m1_err=1, m1_dataIn=0, db_accessType returns to 00; a late db_ready at cycle 12 has no effect.
- Reset mid-operation: res_n low while BUSY with a write outstanding → db_accessType=00 and all readies 0 immediately; after release, the first tie goes to m0.
- Stale-request guard: m0 drops its request the cycle it sees m0_ready → no second db transaction is issued and the FSM returns to IDLE.
